// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the SAP1 control sequencer: control-word bit positions,
// one-hot control masks, opcode values and the flags register layout.
package control_sequencer_pkg;

    localparam int CTRL_WIDTH = 16;

    localparam int B_HLT = 15;
    localparam int B_MI  = 14;
    localparam int B_RI  = 13;
    localparam int B_RO  = 12;
    localparam int B_IO  = 11;
    localparam int B_II  = 10;
    localparam int B_AI  = 9;
    localparam int B_AO  = 8;
    localparam int B_EO  = 7;
    localparam int B_SU  = 6;
    localparam int B_BI  = 5;
    localparam int B_OI  = 4;
    localparam int B_CE  = 3;
    localparam int B_CO  = 2;
    localparam int B_J   = 1;
    localparam int B_FI  = 0;

    localparam logic [CTRL_WIDTH-1:0] C_HLT = 16'h8000;
    localparam logic [CTRL_WIDTH-1:0] C_MI  = 16'h4000;
    localparam logic [CTRL_WIDTH-1:0] C_RI  = 16'h2000;
    localparam logic [CTRL_WIDTH-1:0] C_RO  = 16'h1000;
    localparam logic [CTRL_WIDTH-1:0] C_IO  = 16'h0800;
    localparam logic [CTRL_WIDTH-1:0] C_II  = 16'h0400;
    localparam logic [CTRL_WIDTH-1:0] C_AI  = 16'h0200;
    localparam logic [CTRL_WIDTH-1:0] C_AO  = 16'h0100;
    localparam logic [CTRL_WIDTH-1:0] C_EO  = 16'h0080;
    localparam logic [CTRL_WIDTH-1:0] C_SU  = 16'h0040;
    localparam logic [CTRL_WIDTH-1:0] C_BI  = 16'h0020;
    localparam logic [CTRL_WIDTH-1:0] C_OI  = 16'h0010;
    localparam logic [CTRL_WIDTH-1:0] C_CE  = 16'h0008;
    localparam logic [CTRL_WIDTH-1:0] C_CO  = 16'h0004;
    localparam logic [CTRL_WIDTH-1:0] C_J   = 16'h0002;
    localparam logic [CTRL_WIDTH-1:0] C_FI  = 16'h0001;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LDA = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_STA = 4'd4;
    localparam logic [3:0] OP_LDI = 4'd5;
    localparam logic [3:0] OP_JMP = 4'd6;
    localparam logic [3:0] OP_JC  = 4'd7;
    localparam logic [3:0] OP_JZ  = 4'd8;
    localparam logic [3:0] OP_OUT = 4'd14;
    localparam logic [3:0] OP_HLT = 4'd15;

    typedef struct packed {
        logic carry;
        logic zero;
    } flags_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the retired-instruction and cycle perf counters.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// SAP1 control sequencer: decodes (opcode, step) into the control word, closes the
// step loop via adv/halt, and holds flags, sticky halt/fault and perf counters.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter  int INSTRUCTION_STEPS = 8,
    parameter  int OPCODE_WIDTH      = 4,
    parameter  int PERF_WIDTH        = 16,
    localparam int STEP_WIDTH        = $clog2(INSTRUCTION_STEPS)
) (
    input  logic                    mclk,
    input  logic                    i_rst_n,
    input  logic                    mclk_en,
    input  logic [STEP_WIDTH-1:0]   i_step,
    input  logic [OPCODE_WIDTH-1:0] i_opcode,
    input  logic                    i_carry,
    input  logic                    i_zero,
    output logic [15:0]             o_ctrl,
    output logic                    o_adv,
    output logic                    o_halt,
    output logic                    o_fault,
    output logic [PERF_WIDTH-1:0]   o_retired,
    output logic [PERF_WIDTH-1:0]   o_cycles
);

    localparam logic [STEP_WIDTH-1:0] STEP_0 = STEP_WIDTH'(0);
    localparam logic [STEP_WIDTH-1:0] STEP_1 = STEP_WIDTH'(1);
    localparam logic [STEP_WIDTH-1:0] STEP_2 = STEP_WIDTH'(2);
    localparam logic [STEP_WIDTH-1:0] STEP_3 = STEP_WIDTH'(3);
    localparam logic [STEP_WIDTH-1:0] STEP_4 = STEP_WIDTH'(4);

    flags_t            flags_q;
    logic              halted_q;
    logic              fault_q;
    logic [3:0]        op;
    logic [15:0]       ctrl_d;
    logic              adv_d;
    logic              hlt_dec;
    logic              ill_dec;
    logic              halt_any;

    assign op = 4'(i_opcode);

    always_comb begin
        ctrl_d  = '0;
        adv_d   = 1'b0;
        hlt_dec = 1'b0;
        ill_dec = 1'b0;
        if (!halted_q) begin
            if (i_step == STEP_0) begin
                ctrl_d = C_CO | C_MI;
            end else if (i_step == STEP_1) begin
                ctrl_d = C_RO | C_II | C_CE;
            end else begin
                // Steps past an opcode's last step fall through to ctrl 0 with adv.
                adv_d = 1'b1;
                case (op)
                    OP_NOP: ;
                    OP_LDA: begin
                        if (i_step == STEP_2) begin
                            ctrl_d = C_IO | C_MI;
                            adv_d  = 1'b0;
                        end else if (i_step == STEP_3) begin
                            ctrl_d = C_RO | C_AI;
                        end
                    end
                    OP_ADD, OP_SUB: begin
                        if (i_step == STEP_2) begin
                            ctrl_d = C_IO | C_MI;
                            adv_d  = 1'b0;
                        end else if (i_step == STEP_3) begin
                            ctrl_d = C_RO | C_BI;
                            adv_d  = 1'b0;
                        end else if (i_step == STEP_4) begin
                            ctrl_d = C_EO | C_AI | C_FI | ((op == OP_SUB) ? C_SU : 16'h0000);
                        end
                    end
                    OP_STA: begin
                        if (i_step == STEP_2) begin
                            ctrl_d = C_IO | C_MI;
                            adv_d  = 1'b0;
                        end else if (i_step == STEP_3) begin
                            ctrl_d = C_AO | C_RI;
                        end
                    end
                    OP_LDI: if (i_step == STEP_2) ctrl_d = C_IO | C_AI;
                    OP_JMP: if (i_step == STEP_2) ctrl_d = C_IO | C_J;
                    OP_JC:  if (i_step == STEP_2 && flags_q.carry) ctrl_d = C_IO | C_J;
                    OP_JZ:  if (i_step == STEP_2 && flags_q.zero)  ctrl_d = C_IO | C_J;
                    OP_OUT: if (i_step == STEP_2) ctrl_d = C_AO | C_OI;
                    OP_HLT: begin
                        if (i_step == STEP_2) begin
                            ctrl_d  = C_HLT;
                            adv_d   = 1'b0;
                            hlt_dec = 1'b1;
                        end
                    end
                    default: begin
                        if (i_step == STEP_2) begin
                            adv_d   = 1'b0;
                            ill_dec = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // Halt is visible combinationally so the step counter freezes on the same edge it latches.
    assign halt_any = halted_q | hlt_dec | ill_dec;
    assign o_ctrl   = i_rst_n ? ctrl_d : 16'h0000;
    assign o_adv    = i_rst_n & adv_d;
    assign o_halt   = i_rst_n & halt_any;
    assign o_fault  = fault_q;

    always_ff @(posedge mclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            flags_q  <= '0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else if (mclk_en) begin
            if (ctrl_d[B_FI]) begin
                flags_q.carry <= i_carry;
                flags_q.zero  <= i_zero;
            end
            if (hlt_dec || ill_dec) halted_q <= 1'b1;
            if (ill_dec)            fault_q  <= 1'b1;
        end
    end

    sat_counter #(.WIDTH(PERF_WIDTH)) u_retired (
        .clk   (mclk),
        .rst_n (i_rst_n),
        .en    (mclk_en & adv_d & ~halt_any),
        .clear (1'b0),
        .count (o_retired)
    );

    sat_counter #(.WIDTH(PERF_WIDTH)) u_cycles (
        .clk   (mclk),
        .rst_n (i_rst_n),
        .en    (mclk_en & ~halt_any),
        .clear (1'b0),
        .count (o_cycles)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: directed vectors push expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_control_sequencer;
    import control_sequencer_pkg::*;

    localparam int PW = 16;
    localparam int EW = 16 + 3 + 2 * PW;

    logic          mclk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          mclk_en = 1'b1;
    logic [2:0]    i_step = '0;
    logic [3:0]    i_opcode = '0;
    logic          i_carry = 1'b0;
    logic          i_zero = 1'b0;
    logic [15:0]   o_ctrl;
    logic          o_adv;
    logic          o_halt;
    logic          o_fault;
    logic [PW-1:0] o_retired;
    logic [PW-1:0] o_cycles;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;
    int            n_checks = 0;
    int            n_err = 0;
    int            vec_id = 0;
    int            mon_id = 0;
    logic [PW-1:0] m_ret = '0;
    logic [PW-1:0] m_cyc = '0;

    // clock / reset block
    always #5 mclk = ~mclk;

    control_sequencer #(
        .INSTRUCTION_STEPS (8),
        .OPCODE_WIDTH      (4),
        .PERF_WIDTH        (PW)
    ) dut (
        .mclk      (mclk),
        .i_rst_n   (i_rst_n),
        .mclk_en   (mclk_en),
        .i_step    (i_step),
        .i_opcode  (i_opcode),
        .i_carry   (i_carry),
        .i_zero    (i_zero),
        .o_ctrl    (o_ctrl),
        .o_adv     (o_adv),
        .o_halt    (o_halt),
        .o_fault   (o_fault),
        .o_retired (o_retired),
        .o_cycles  (o_cycles)
    );

    // driver: one vector per cycle, inputs set just after the rising edge
    task automatic apply(input logic rst, input logic en, input int step, input int op,
                         input logic c, input logic z, input logic [15:0] e_ctrl,
                         input logic e_adv, input logic e_halt, input logic e_fault);
        @(posedge mclk);
        #1;
        i_rst_n  = rst;
        mclk_en  = en;
        i_step   = 3'(step);
        i_opcode = 4'(op);
        i_carry  = c;
        i_zero   = z;
        if (!rst) begin
            m_ret = '0;
            m_cyc = '0;
        end
        exp_q.push_back({e_ctrl, e_adv, e_halt, e_fault, m_ret, m_cyc});
        vec_id++;
        if (rst && en && !e_halt) begin
            if (m_cyc != '1) m_cyc++;
            if (e_adv && m_ret != '1) m_ret++;
        end
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s vec=%0d actual=%h expected=%h", name, mon_id, act, expv);
        end
    endtask

    // monitor / scoreboard
    always @(negedge mclk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            mon_id++;
            check("ctrl",    o_ctrl,              mon_e[50:35]);
            check("adv",     {15'b0, o_adv},      {15'b0, mon_e[34]});
            check("halt",    {15'b0, o_halt},     {15'b0, mon_e[33]});
            check("fault",   {15'b0, o_fault},    {15'b0, mon_e[32]});
            check("retired", o_retired,           mon_e[31:16]);
            check("cycles",  o_cycles,            mon_e[15:0]);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog vec=%0d actual=timeout expected=finish", vec_id);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset held: decode of step 0 must be masked
        apply(0, 1, 0, 0, 0, 0, 16'h0000, 0, 0, 0);
        // LDA step sweep
        apply(1, 1, 0, 1, 0, 0, C_CO | C_MI,        0, 0, 0);
        apply(1, 1, 1, 1, 0, 0, C_RO | C_II | C_CE, 0, 0, 0);
        apply(1, 1, 2, 1, 0, 0, C_IO | C_MI,        0, 0, 0);
        apply(1, 1, 3, 1, 0, 0, C_RO | C_AI,        1, 0, 0);
        // ADD producing zero, flags captured at step 4
        apply(1, 1, 0, 2, 0, 0, C_CO | C_MI,        0, 0, 0);
        apply(1, 1, 1, 2, 0, 0, C_RO | C_II | C_CE, 0, 0, 0);
        apply(1, 1, 2, 2, 0, 0, C_IO | C_MI,        0, 0, 0);
        apply(1, 1, 3, 2, 0, 0, C_RO | C_BI,        0, 0, 0);
        apply(1, 1, 4, 2, 0, 1, C_EO | C_AI | C_FI, 1, 0, 0);
        apply(1, 1, 2, 8, 0, 0, C_IO | C_J,         1, 0, 0);
        apply(1, 1, 2, 7, 0, 0, 16'h0000,           1, 0, 0);
        // SUB with carry, Z cleared
        apply(1, 1, 4, 3, 1, 0, C_EO | C_AI | C_FI | C_SU, 1, 0, 0);
        apply(1, 1, 2, 8, 0, 0, 16'h0000,           1, 0, 0);
        apply(1, 1, 2, 7, 0, 0, C_IO | C_J,         1, 0, 0);
        // clock enable low: decode visible, nothing latched or counted
        apply(1, 0, 4, 3, 0, 1, C_EO | C_AI | C_FI | C_SU, 1, 0, 0);
        apply(1, 1, 2, 7, 0, 0, C_IO | C_J,         1, 0, 0);
        apply(1, 1, 2, 8, 0, 0, 16'h0000,           1, 0, 0);
        // remaining opcodes and recovery steps
        apply(1, 1, 2, 4, 0, 0, C_IO | C_MI,        0, 0, 0);
        apply(1, 1, 3, 4, 0, 0, C_AO | C_RI,        1, 0, 0);
        apply(1, 1, 2, 5, 0, 0, C_IO | C_AI,        1, 0, 0);
        apply(1, 1, 2, 6, 0, 0, C_IO | C_J,         1, 0, 0);
        apply(1, 1, 2, 14, 0, 0, C_AO | C_OI,       1, 0, 0);
        apply(1, 1, 2, 0, 0, 0, 16'h0000,           1, 0, 0);
        apply(1, 1, 5, 5, 0, 0, 16'h0000,           1, 0, 0);
        apply(1, 1, 7, 0, 0, 0, 16'h0000,           1, 0, 0);
        apply(1, 1, 1, 15, 0, 0, C_RO | C_II | C_CE, 0, 0, 0);
        // reset mid ADD step 3, then flags must be clear
        apply(1, 1, 3, 2, 0, 0, C_RO | C_BI,        0, 0, 0);
        apply(0, 1, 3, 2, 0, 0, 16'h0000,           0, 0, 0);
        apply(1, 1, 2, 8, 1, 1, 16'h0000,           1, 0, 0);
        apply(1, 1, 2, 7, 1, 1, 16'h0000,           1, 0, 0);
        // illegal opcode: halt same cycle, fault latched, sticky
        apply(1, 1, 2, 10, 0, 0, 16'h0000,          0, 1, 0);
        apply(1, 1, 2, 10, 0, 0, 16'h0000,          0, 1, 1);
        apply(1, 1, 3, 1, 0, 0, 16'h0000,           0, 1, 1);
        apply(1, 1, 4, 2, 1, 1, 16'h0000,           0, 1, 1);
        apply(0, 1, 0, 0, 0, 0, 16'h0000,           0, 0, 0);
        // HLT
        apply(1, 1, 0, 15, 0, 0, C_CO | C_MI,       0, 0, 0);
        apply(1, 1, 1, 15, 0, 0, C_RO | C_II | C_CE, 0, 0, 0);
        apply(1, 1, 2, 15, 0, 0, C_HLT,             0, 1, 0);
        apply(1, 1, 2, 15, 0, 0, 16'h0000,          0, 1, 0);
        apply(1, 1, 4, 2, 1, 1, 16'h0000,           0, 1, 0);
        apply(1, 0, 2, 0, 0, 0, 16'h0000,           0, 1, 0);

        @(negedge mclk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain actual=%0d expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
